udma_evt_queue: RTL and testbench

//  Collects single-cycle event pulses from N_SRC uDMA/SoC sources and serialises them into
//  an ordered 8-bit event-ID stream. Feeds udma_ctrl's event_valid_i/event_data_i/event_ready_o

---
 rtl/udma_evt_queue.sv | 76 +++++++
 tb/tb_udma_evt_queue.sv | 136 +++++++++++++
 2 files changed

// File: rtl/udma_evt_queue.sv
// udma_evt_queue: round-robin event-pulse collector serialising source IDs into an 8-bit FIFO stream.
// Optional macro UDMA_EVT_QUEUE_OVF_CNT_EN adds the saturating ovf_cnt_o drop counter.
module udma_evt_queue #(
  parameter int N_SRC    = 4,
  parameter int DEPTH    = 8,
  parameter int EVT_BASE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] src_evt_i,
  output logic             event_valid_o,
  output logic [7:0]       event_data_o,
  input  logic             event_ready_i,
  input  logic             ovf_clr_i,
  output logic             ovf_o,
  output logic [N_SRC-1:0] ovf_src_o
`ifdef UDMA_EVT_QUEUE_OVF_CNT_EN
  ,
  output logic [15:0]      ovf_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  logic [N_SRC-1:0] pend, gnt_vec, drop;
  logic [PW-1:0] ptr, gidx;
  logic found, grant, pop, full;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign event_valid_o = cnt != '0;
  assign event_data_o = event_valid_o ? mem[rd] : 8'd0;
  assign pop = event_valid_o & event_ready_i;
  assign grant = found & (!full | pop);
  assign gnt_vec = grant ? (N_SRC'(1) << gidx) : '0;
  assign drop = src_evt_i & pend & ~gnt_vec;
  assign ovf_o = |ovf_src_o;
  // Descending scan so the closest set bit after ptr is the last one written.
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = N_SRC; k >= 1; k--)
      if (pend[PW'((int'(ptr) + k) % N_SRC)]) begin
        found = 1'b1;
        gidx = PW'((int'(ptr) + k) % N_SRC);
      end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
      ptr <= PW'(N_SRC - 1);
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      ovf_src_o <= '0;
    end else begin
      pend <= (pend & ~gnt_vec) | src_evt_i;
      if (grant) begin
        ptr <= gidx;
        wr <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      cnt <= cnt + (AW+1)'(grant) - (AW+1)'(pop);
      ovf_src_o <= (ovf_clr_i ? '0 : ovf_src_o) | drop;
    end
  end
  always_ff @(posedge clk_i)
    if (grant) mem[wr] <= 8'(EVT_BASE) + 8'(gidx);
`ifdef UDMA_EVT_QUEUE_OVF_CNT_EN
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, ovf_clr_i ? 16'd0 : ovf_cnt_o} + 17'($countones(drop));
  always_ff @(posedge clk_i)
    if (rst_i) ovf_cnt_o <= '0;
    else ovf_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
`endif
endmodule

// File: tb/tb_udma_evt_queue.sv
// tb_udma_evt_queue: vector table for latency/ordering plus scoreboarded back-pressure, overflow and reset sequences.
module tb_udma_evt_queue;
  logic clk, rst, rdy, clr;
  logic [3:0] src;
  logic valid, ovf;
  logic [7:0] data;
  logic [3:0] ovf_src;
  int checks = 0, errors = 0;
  logic mon_en = 0;
  logic [7:0] sb[$];
`ifdef UDMA_EVT_QUEUE_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif
  udma_evt_queue dut (
    .clk_i(clk), .rst_i(rst), .src_evt_i(src),
    .event_valid_o(valid), .event_data_o(data), .event_ready_i(rdy),
    .ovf_clr_i(clr), .ovf_o(ovf), .ovf_src_o(ovf_src)
`ifdef UDMA_EVT_QUEUE_OVF_CNT_EN
    , .ovf_cnt_o(ovf_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [3:0] src;
    logic rdy;
    logic v;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (mon_en && valid && rdy) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'(data), 32'hFFFF);
      else chk("sb_data", 32'(data), 32'(sb.pop_front()));
    end
  initial begin
    clk = 0; rst = 1; src = 0; rdy = 0; clr = 0;
    tick; tick;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_ovf_src", 32'(ovf_src), 0);
    rst = 0;
    tbl = '{
      '{0, 4'b0100, 1, 0, 0}, '{0, 4'b0000, 1, 1, 2}, '{0, 4'b0000, 1, 0, 0},
      '{1, 4'b0000, 1, 0, 0},
      '{0, 4'b1111, 1, 0, 0}, '{0, 4'b0000, 1, 1, 0}, '{0, 4'b0000, 1, 1, 1},
      '{0, 4'b0000, 1, 1, 2}, '{0, 4'b0000, 1, 1, 3}, '{0, 4'b0000, 1, 0, 0},
      '{0, 4'b1010, 1, 0, 0}, '{0, 4'b0000, 1, 1, 1}, '{0, 4'b0000, 1, 1, 3},
      '{0, 4'b0000, 1, 0, 0},
      '{0, 4'b1001, 1, 0, 0}, '{0, 4'b0000, 1, 1, 0}, '{0, 4'b0000, 1, 1, 3},
      '{0, 4'b0000, 1, 0, 0}
    };
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; src = tbl[i].src; rdy = tbl[i].rdy;
      tick;
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_data", i), 32'(data), 32'(tbl[i].d));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 0);
    end
    rst = 1; src = 0; rdy = 0;
    tick;
    rst = 0;
    for (int b = 0; b < 2; b++) begin
      src = 4'hF; tick; src = 0;
      repeat (5) tick;
    end
    chk("full_valid", 32'(valid), 1);
    chk("full_head", 32'(data), 0);
    repeat (3) tick;
    chk("full_head_stable", 32'(data), 0);
    chk("full_no_drop", 32'(ovf), 0);
    src = 4'b0010; tick; tick; src = 0;
    chk("drop_src", 32'(ovf_src), 32'b0010);
    chk("drop_ovf", 32'(ovf), 1);
    clr = 1; src = 4'b0010; tick; clr = 0; src = 0;
    chk("clr_vs_drop", 32'(ovf_src), 32'b0010);
    clr = 1; tick; clr = 0;
    chk("clr_src", 32'(ovf_src), 0);
    chk("clr_ovf", 32'(ovf), 0);
    src = 4'b1101; tick; src = 0;
    chk("pend_no_drop", 32'(ovf), 0);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 4; s++) sb.push_back(8'(s));
    mon_en = 1; rdy = 1;
    repeat (12) tick;
    mon_en = 0;
    chk("drain_all", 32'(sb.size()), 0);
    chk("drain_empty", 32'(valid), 0);
    rdy = 0;
    src = 4'hF; tick; src = 0;
    repeat (4) tick;
    src = 4'b0011; tick; tick; src = 0;
    tick;
    chk("pre_rst_valid", 32'(valid), 1);
    chk("pre_rst_ovf", 32'(ovf), 1);
    rst = 1; tick; rst = 0;
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_ovf_src", 32'(ovf_src), 0);
    repeat (3) tick;
    chk("post_rst_idle", 32'(valid), 0);
`ifdef UDMA_EVT_QUEUE_OVF_CNT_EN
    for (int b = 0; b < 2; b++) begin
      src = 4'hF; tick; src = 0;
      repeat (5) tick;
    end
    src = 4'hF; tick;
    src = 4'b0111; tick; src = 0;
    chk("cnt_three", 32'(ovf_cnt), 3);
    clr = 1; tick; clr = 0;
    chk("cnt_clr", 32'(ovf_cnt), 0);
    clr = 1; src = 4'hF; tick; clr = 0;
    chk("cnt_clr_drop", 32'(ovf_cnt), 4);
    repeat (17500) tick;
    src = 0;
    chk("cnt_sat", 32'(ovf_cnt), 32'hFFFF);
    rst = 1; tick; rst = 0;
    chk("cnt_rst", 32'(ovf_cnt), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
